// File: rtl/pipe_collision.sv
// Pipe scroller, bird collision detector and score keeper for the flappy-bird game.
// Optional macro PIPE_COLLISION_BOUNDS_EN adds floor/ceiling collisions.
module pipe_collision #(
    parameter int TICK_DIV  = 1000000,
    parameter int SPEED     = 2,
    parameter int PIPE_W    = 60,
    parameter int GAP_H     = 120,
    parameter int BIRD_SIZE = 20,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SPACING   = 320
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [9:0] YBird,
    input  logic [9:0] XBird,
    output logic [9:0] PipeX0,
    output logic [9:0] PipeX1,
    output logic [9:0] GapY0,
    output logic [9:0] GapY1,
    output logic [7:0] Score,
    output logic       GameOver,
    output logic       Hit
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [10:0] SPEED_W  = 11'(SPEED);
    localparam logic [10:0] PIPEW_W  = 11'(PIPE_W);
    localparam logic [10:0] GAPH_W   = 11'(GAP_H);
    localparam logic [10:0] BIRD_W   = 11'(BIRD_SIZE);
    localparam logic [10:0] SCRH_W   = 11'(SCREEN_H);
    localparam logic [10:0] CEIL_W   = 11'd1000;
    localparam logic [9:0]  PIPE0_RST = 10'(SCREEN_W);
    localparam logic [9:0]  PIPE1_RST = 10'(SCREEN_W + SPACING);
    localparam logic [9:0]  GAP_RST   = 10'd200;
    localparam logic [9:0]  GAP_MIN   = 10'd40;

`ifdef PIPE_COLLISION_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        RUN  = 3'b010,
        DEAD = 3'b100
    } stateT;

    stateT         state_q, state_d;
    logic [9:0]    pipeX0_q, pipeX0_d, pipeX1_q, pipeX1_d;
    logic [9:0]    gapY0_q, gapY0_d, gapY1_q, gapY1_d;
    logic [7:0]    score_q, score_d;
    logic          gameOver_q, gameOver_d;
    logic          hit_q, hit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    lfsr_q, lfsr_d;

    logic [10:0]   birdX, birdY;
    logic          tick, collision, boundHit;
    logic          score0, score1;
    logic [1:0]    scoreAdd;
    logic [8:0]    scoreSum;
    logic [9:0]    newGap;

    function automatic logic pipeHit(input logic [10:0] px, input logic [10:0] gy,
                                     input logic [10:0] bx, input logic [10:0] by);
        logic horiz, outside;
        horiz   = (bx + BIRD_W > px) && (bx < px + PIPEW_W);
        outside = (by < gy) || (by + BIRD_W > gy + GAPH_W);
        return horiz && outside;
    endfunction

    // The pipe's trailing edge steps past the bird's left edge during this move.
    function automatic logic pipeScores(input logic [10:0] px, input logic [10:0] bx);
        return (px >= SPEED_W) && (px + PIPEW_W >= bx) && (px + PIPEW_W - SPEED_W < bx);
    endfunction

    function automatic logic [9:0] pipeStep(input logic [9:0] px);
        return (px < SPEED_W[9:0]) ? PIPE0_RST : px - SPEED_W[9:0];
    endfunction

    assign birdX     = {1'b0, XBird};
    assign birdY     = {1'b0, YBird};
    assign tick      = (cnt_q == TICK_LAST);
    assign boundHit  = (birdY + BIRD_W >= SCRH_W) || (birdY >= CEIL_W);
    assign collision = pipeHit({1'b0, pipeX0_q}, {1'b0, gapY0_q}, birdX, birdY)
                     | pipeHit({1'b0, pipeX1_q}, {1'b0, gapY1_q}, birdX, birdY)
                     | (BOUNDS_EN & boundHit);
    assign score0    = pipeScores({1'b0, pipeX0_q}, birdX);
    assign score1    = pipeScores({1'b0, pipeX1_q}, birdX);
    assign scoreAdd  = {1'b0, score0} + {1'b0, score1};
    assign scoreSum  = {1'b0, score_q} + {7'd0, scoreAdd};
    assign newGap    = GAP_MIN + {2'b00, lfsr_q};

    always_comb begin
        state_d    = state_q;
        pipeX0_d   = pipeX0_q;
        pipeX1_d   = pipeX1_q;
        gapY0_d    = gapY0_q;
        gapY1_d    = gapY1_q;
        score_d    = score_q;
        gameOver_d = gameOver_q;
        hit_d      = 1'b0;
        cnt_d      = cnt_q;
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (state_q)
            IDLE: begin
                pipeX0_d   = PIPE0_RST;
                pipeX1_d   = PIPE1_RST;
                gapY0_d    = GAP_RST;
                gapY1_d    = GAP_RST;
                score_d    = 8'd0;
                cnt_d      = '0;
                gameOver_d = 1'b0;
                state_d    = RUN;
            end
            RUN: begin
                if (collision) begin
                    state_d    = DEAD;
                    gameOver_d = 1'b1;
                    hit_d      = 1'b1;
                end else begin
                    gameOver_d = 1'b0;
                    if (tick) begin
                        cnt_d    = '0;
                        pipeX0_d = pipeStep(pipeX0_q);
                        pipeX1_d = pipeStep(pipeX1_q);
                        if (pipeX0_q < SPEED_W[9:0]) gapY0_d = newGap;
                        if (pipeX1_q < SPEED_W[9:0]) gapY1_d = newGap;
                        score_d  = scoreSum[8] ? 8'hFF : scoreSum[7:0];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DEAD: begin
                gameOver_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Dropping Start abandons the game from any state; only the LFSR keeps running.
        if (!Start) begin
            state_d    = IDLE;
            pipeX0_d   = PIPE0_RST;
            pipeX1_d   = PIPE1_RST;
            gapY0_d    = GAP_RST;
            gapY1_d    = GAP_RST;
            score_d    = 8'd0;
            cnt_d      = '0;
            gameOver_d = 1'b0;
            hit_d      = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            pipeX0_q   <= PIPE0_RST;
            pipeX1_q   <= PIPE1_RST;
            gapY0_q    <= GAP_RST;
            gapY1_q    <= GAP_RST;
            score_q    <= 8'd0;
            gameOver_q <= 1'b0;
            hit_q      <= 1'b0;
            cnt_q      <= '0;
            lfsr_q     <= 8'hA5;
        end else begin
            state_q    <= state_d;
            pipeX0_q   <= pipeX0_d;
            pipeX1_q   <= pipeX1_d;
            gapY0_q    <= gapY0_d;
            gapY1_q    <= gapY1_d;
            score_q    <= score_d;
            gameOver_q <= gameOver_d;
            hit_q      <= hit_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign PipeX0   = pipeX0_q;
    assign PipeX1   = pipeX1_q;
    assign GapY0    = gapY0_q;
    assign GapY1    = gapY1_q;
    assign Score    = score_q;
    assign GameOver = gameOver_q;
    assign Hit      = hit_q;

endmodule

// File: tb/tb_pipe_collision.sv
// Scoreboard bench for pipe_collision (TICK_DIV=4): a game-rule model predicts every cycle's outputs.
// Honours PIPE_COLLISION_BOUNDS_EN the same way the design does.
module tb_pipe_collision;

    typedef struct packed {
        logic [9:0] px0;
        logic [9:0] px1;
        logic [9:0] gy0;
        logic [9:0] gy1;
        logic [7:0] score;
        logic       go;
        logic       hit;
    } outT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [9:0] xBird = 10'd0;
    logic [9:0] yBird = 10'd0;
    logic [9:0] pipeX0, pipeX1, gapY0, gapY1;
    logic [7:0] score;
    logic       gameOver, hit;

    outT expQ[$];
    int  checks = 0;
    int  failures = 0;
    int  cycle = 0;
    bit  armed = 0;
    bit  driverDone = 0;

    // Reference game state: 0 idle, 1 running, 2 dead.
    int mState, mCnt, mScore, mLfsr;
    int mPx[2];
    int mGy[2];
    bit mGo, mHit;

    pipe_collision #(.TICK_DIV(4)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .YBird(yBird), .XBird(xBird),
        .PipeX0(pipeX0), .PipeX1(pipeX1), .GapY0(gapY0), .GapY1(gapY1),
        .Score(score), .GameOver(gameOver), .Hit(hit)
    );

    always #5 clk = ~clk;

    task automatic modelReload();
        mState = 0; mCnt = 0; mScore = 0;
        mPx[0] = 640; mPx[1] = 960;
        mGy[0] = 200; mGy[1] = 200;
        mGo = 0; mHit = 0;
    endtask

    task automatic modelStep(input bit rst, input bit st, input int xb, input int yb);
        int nextLfsr, passed;
        bit coll;
        if (!rst) begin
            modelReload();
            mLfsr = 8'hA5;
            return;
        end
        nextLfsr = ((mLfsr << 1) & 255) | (((mLfsr >> 7) ^ (mLfsr >> 5) ^ (mLfsr >> 4) ^ (mLfsr >> 3)) & 1);
        if (!st) begin
            modelReload();
        end else if (mState == 0) begin
            mState = 1;
            mHit = 0;
        end else if (mState == 2) begin
            mHit = 0;
        end else begin
            coll = 0;
            for (int i = 0; i < 2; i++)
                if (xb + 20 > mPx[i] && xb < mPx[i] + 60 && (yb < mGy[i] || yb + 20 > mGy[i] + 120))
                    coll = 1;
`ifdef PIPE_COLLISION_BOUNDS_EN
            if (yb + 20 >= 480 || yb >= 1000) coll = 1;
`endif
            if (coll) begin
                mState = 2; mGo = 1; mHit = 1;
            end else begin
                mHit = 0;
                if (mCnt == 3) begin
                    mCnt = 0;
                    passed = 0;
                    for (int i = 0; i < 2; i++) begin
                        if (mPx[i] >= 2 && mPx[i] + 60 >= xb && mPx[i] + 58 < xb) passed++;
                        if (mPx[i] < 2) begin
                            mPx[i] = 640;
                            mGy[i] = 40 + mLfsr;
                        end else begin
                            mPx[i] -= 2;
                        end
                    end
                    mScore = (mScore + passed > 255) ? 255 : mScore + passed;
                end else begin
                    mCnt++;
                end
            end
        end
        mLfsr = nextLfsr;
    endtask

    task automatic applyStimulus(input bit rst, input bit st, input int xb, input int yb, input int n);
        outT e;
        repeat (n) begin
            @(negedge clk);
            reset = rst; start = st;
            xBird = 10'(xb); yBird = 10'(yb);
            modelStep(rst, st, xb, yb);
            e.px0 = 10'(mPx[0]); e.px1 = 10'(mPx[1]);
            e.gy0 = 10'(mGy[0]); e.gy1 = 10'(mGy[1]);
            e.score = 8'(mScore); e.go = mGo; e.hit = mHit;
            expQ.push_back(e);
            armed = 1;
        end
    endtask

    task automatic checkOutput(input outT e);
        outT a;
        a = '{pipeX0, pipeX1, gapY0, gapY1, score, gameOver, hit};
        checks++;
        if (a !== e) begin
            failures++;
            $display("[TB] FAIL outputs cycle=%0d got px0=%0d px1=%0d gy0=%0d gy1=%0d score=%0d go=%0b hit=%0b exp px0=%0d px1=%0d gy0=%0d gy1=%0d score=%0d go=%0b hit=%0b",
                     cycle, a.px0, a.px1, a.gy0, a.gy1, a.score, a.go, a.hit,
                     e.px0, e.px1, e.gy0, e.gy1, e.score, e.go, e.hit);
        end
    endtask

    // Monitor: every edge is an output event, paired with the oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (expQ.size() > 0) begin
                checkOutput(expQ.pop_front());
            end else if (armed && !driverDone) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard cycle=%0d got empty queue exp a prediction", cycle);
            end
        end
    end

    initial begin
        int xb, yb;
        applyStimulus(0, 0, 0, 0, 3);
        applyStimulus(1, 0, 500, 220, 3);
        // Bird in pipe 0's gap: both pipes pass, pipe 0 wraps with a fresh gap.
        applyStimulus(1, 1, 500, 220, 1400);
        applyStimulus(1, 0, 500, 220, 2);
        // Bird above the gap: pipe 0 eventually clips it.
        applyStimulus(1, 1, 500, 100, 300);
        applyStimulus(1, 1, 300, 400, 10);
        applyStimulus(1, 0, 500, 100, 2);
        // Floor, ceiling-underflow and top-of-screen positions away from pipes.
        applyStimulus(1, 1, 100, 460, 20);
        applyStimulus(1, 0, 100, 460, 2);
        applyStimulus(1, 1, 100, 1010, 20);
        applyStimulus(1, 0, 100, 1010, 2);
        applyStimulus(1, 1, 100, 0, 20);
        // Reset mid-run.
        applyStimulus(1, 1, 100, 220, 50);
        applyStimulus(0, 1, 100, 220, 1);
        applyStimulus(1, 1, 100, 220, 10);
        // Random play: bird wanders, occasional Start drops and resets.
        xb = 500; yb = 220;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) xb = $urandom_range(0, 639);
            if ($urandom_range(0, 15) == 0) yb = $urandom_range(0, 15) == 0 ? $urandom_range(0, 1023) : $urandom_range(40, 320);
            applyStimulus($urandom_range(0, 499) != 0, $urandom_range(0, 199) != 0, xb, yb, 1);
        end
        driverDone = 1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain got %0d pending exp 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
